dual_master_regbank: RTL and testbench
======================================

Name: dual_master_regbank

Overview:
- Parametrised mailbox register bank between two bus masters: side A (HPS) and side B (NIOS).
- Generalises the fixed HPS/NIOS cross-connected register set to NUM_REGS shared registers with per-register write ownership, a read-only status word, and per-register change-doorbell interrupts with pending and enable masks on each side.
- Sits beside the video capture path; the capture status bits feed status_in.

Parameters:
- DATA_W, 32, register and bus data width.
- ADDR_W, 3, word address width per side; must satisfy 2^ADDR_W >= NUM_REGS+3.
- NUM_REGS, 4, number of shared registers.
- A_OWNED, 4'b0101, NUM_REGS-bit mask. Bit i=1 means reg i is writable only by A; bit i=0 means writable only by B.
- STATUS_W, 8, width of status_in; zero-extended to DATA_W on read.

Ports:
- clk  in  1  main clock.
- rst  in  1  asynchronous reset, active-low.
- status_in  in  STATUS_W  live status bits, sampled on read.
- a_address  in  ADDR_W  side A word address.
- a_bus_enable  in  1  side A access request.
- a_rw  in  1  side A direction: 1=read, 0=write.
- a_write_data  in  DATA_W  side A write data.
- a_read_data  out  DATA_W  side A read data; valid with a_acknowledge.
- a_acknowledge  out  1  side A one-cycle completion pulse.
- a_irq  out  1  side A interrupt.
- b_*  same set as a_*, for side B.
- reg_out  out  NUM_REGS*DATA_W  flat copy of the shared registers for fabric use; reg i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset: asynchronous, active-low. Clears all shared regs, pending masks, enable masks, read_data, acknowledge and irq to 0.
- Address map, identical on both sides:
  - 0..NUM_REGS-1: shared regs.
  - NUM_REGS: status, read-only.
  - NUM_REGS+1: own irq pending. Read returns pending bits; write is write-1-to-clear.
  - NUM_REGS+2: own irq enable, read/write. Only low NUM_REGS bits are stored; upper bits read 0.
  - Above that: reads return 0; writes are acknowledged and discarded.
- Access acceptance: an access is accepted at a clock edge when bus_enable=1 and acknowledge=0.
  - acknowledge goes high for exactly the following cycle.
  - read_data holds the result during that cycle and is 0 in every other cycle.
  - If bus_enable is held high, the bank accepts at most one access every 2 cycles.
- Read latency: 1 cycle. Status reads return status_in as sampled at the accepting edge.
- Shared reg write by its owner: the reg updates at the accepting edge. The peer's pending bit i is set at the same edge, even when the written value equals the old value.
- Shared reg write by the non-owner: acknowledged, reg unchanged, no pending bit set.
- Both sides access in the same cycle: the accesses are independent. Exclusive ownership rules out write conflicts.
- Pending bit set and W1C on the same bit in the same cycle: set wins and the bit stays 1.
- Reading a reg in the same cycle the owner writes it returns the old value.
- irq: registered, x_irq <= |(x_pending & x_enable). It rises 1 cycle after the pending/enable state that causes it. Clearing enable drops irq 1 cycle later; pending is kept.
- reg_out reflects the register flops directly, with no extra latency.
- Reset asserted mid-access: ack and data are cleared immediately; the access is lost.

Optional Feature:
- Macro: DUAL_MASTER_REGBANK_BYTEEN_EN.
- Defined: adds ports a_byteenable and b_byteenable, each in, DATA_W/8 bits.
  - Shared reg and enable writes update only the enabled bytes.
  - W1C on pending only acts on bits within enabled bytes.
  - A write with byteenable=0 is acknowledged, changes nothing and sets no pending bit.
- Undefined: no byteenable ports; every write is a full-word write.

Test Plan:
- Reset, then A reads addr 0..7 -> every read_data=0, each ack exactly 1 cycle wide, a_irq=b_irq=0.
- B writes 0x0000_00FF to enable (addr 6). A writes 0xDEADBEEF to reg 0 (A-owned) -> B reads reg 0 = 0xDEADBEEF, B pending (addr 5)=0x1, b_irq high 1 cycle after the write edge.
- B writes 0x0000_0001 to addr 5 -> b_irq low 1 cycle later. In a separate case, A rewrites reg 0 in the same cycle as B's W1C -> pending stays 0x1.
- A writes 0x1234 to reg 1 (B-owned) -> acknowledged, reg 1 stays 0, A pending and B pending stay 0.
- status_in=8'hA5, B reads addr 4 -> 0x0000_00A5. B write to addr 4 -> acknowledged, no change. A and B read simultaneously -> both acked the same cycle.
- With DUAL_MASTER_REGBANK_BYTEEN_EN defined: A writes 0xFFFF_FFFF to reg 2 with byteenable=4'b0010 -> reg 2 reads 0x0000_FF00. A write with byteenable=0 -> no pending bit set.

Source files
------------

// File: rtl/dual_master_regbank.sv
// Two-master mailbox register bank: owner-writable shared regs, status word, per-side change doorbells.
// Optional byte enables on both sides when DUAL_MASTER_REGBANK_BYTEEN_EN is defined.
module dual_master_regbank #(
  parameter int                  DATA_W   = 32,
  parameter int                  ADDR_W   = 3,
  parameter int                  NUM_REGS = 4,
  parameter logic [NUM_REGS-1:0] A_OWNED  = 4'b0101,
  parameter int                  STATUS_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [STATUS_W-1:0]          status_in,
  input  logic [ADDR_W-1:0]            a_address,
  input  logic                         a_bus_enable,
  input  logic                         a_rw,
  input  logic [DATA_W-1:0]            a_write_data,
  output logic [DATA_W-1:0]            a_read_data,
  output logic                         a_acknowledge,
  output logic                         a_irq,
  input  logic [ADDR_W-1:0]            b_address,
  input  logic                         b_bus_enable,
  input  logic                         b_rw,
  input  logic [DATA_W-1:0]            b_write_data,
  output logic [DATA_W-1:0]            b_read_data,
  output logic                         b_acknowledge,
  output logic                         b_irq,
`ifdef DUAL_MASTER_REGBANK_BYTEEN_EN
  input  logic [DATA_W/8-1:0]          a_byteenable,
  input  logic [DATA_W/8-1:0]          b_byteenable,
`endif
  output logic [NUM_REGS*DATA_W-1:0]   reg_out
);

  localparam int                NB          = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] ADDR_PEND   = ADDR_W'(NUM_REGS + 1);
  localparam logic [ADDR_W-1:0] ADDR_ENA    = ADDR_W'(NUM_REGS + 2);

  // Side-indexed views of the two bus ports: index 0 is A, index 1 is B.
  logic [ADDR_W-1:0]   addr  [2];
  logic                en    [2];
  logic                rw    [2];
  logic [DATA_W-1:0]   wdata [2];
  logic [DATA_W-1:0]   bmask [2];
  logic [1:0]          be_any;

  assign addr[0]  = a_address;     assign addr[1]  = b_address;
  assign en[0]    = a_bus_enable;  assign en[1]    = b_bus_enable;
  assign rw[0]    = a_rw;          assign rw[1]    = b_rw;
  assign wdata[0] = a_write_data;  assign wdata[1] = b_write_data;

`ifdef DUAL_MASTER_REGBANK_BYTEEN_EN
  logic [NB-1:0] be [2];
  assign be[0] = a_byteenable;
  assign be[1] = b_byteenable;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      bmask[s]  = '0;
      for (int b = 0; b < NB; b++) bmask[s][b*8 +: 8] = {8{be[s][b]}};
      be_any[s] = |be[s];
    end
  end
`else
  assign bmask[0] = '1;
  assign bmask[1] = '1;
  assign be_any   = 2'b11;
`endif

  logic [DATA_W-1:0]   regs    [NUM_REGS];
  logic [NUM_REGS-1:0] pend    [2];
  logic [NUM_REGS-1:0] ena     [2];
  logic                ack     [2];
  logic [DATA_W-1:0]   rdata   [2];
  logic                irq     [2];

  logic [1:0]          acc, wr;
  logic [NUM_REGS-1:0] reg_we;
  logic [DATA_W-1:0]   reg_wd  [NUM_REGS];
  logic [NUM_REGS-1:0] set     [2];
  logic [NUM_REGS-1:0] clr     [2];
  logic [1:0]          ena_we;
  logic [NUM_REGS-1:0] ena_wd  [2];
  logic [DATA_W-1:0]   rmux    [2];

  // An access is taken only while ack is low, so a held enable yields one access every 2 cycles.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      acc[s] = en[s] & ~ack[s];
      wr[s]  = acc[s] & ~rw[s];
    end
  end

  // Only the owning side can write a shared reg; its write rings the peer's doorbell.
  always_comb begin
    int o;
    for (int i = 0; i < NUM_REGS; i++) begin
      o         = A_OWNED[i] ? 0 : 1;
      reg_we[i] = wr[o] && be_any[o] && (addr[o] == ADDR_W'(i));
      reg_wd[i] = (regs[i] & ~bmask[o]) | (wdata[o] & bmask[o]);
    end
    set[0] = reg_we & ~A_OWNED;
    set[1] = reg_we & A_OWNED;
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      clr[s]    = '0;
      ena_we[s] = 1'b0;
      if (wr[s] && addr[s] == ADDR_PEND)
        clr[s] = wdata[s][NUM_REGS-1:0] & bmask[s][NUM_REGS-1:0];
      if (wr[s] && addr[s] == ADDR_ENA)
        ena_we[s] = 1'b1;
      ena_wd[s] = (ena[s] & ~bmask[s][NUM_REGS-1:0])
                | (wdata[s][NUM_REGS-1:0] & bmask[s][NUM_REGS-1:0]);
    end
  end

  // Read mux sees the pre-edge flop values, so a same-cycle write is not visible yet.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      rmux[s] = '0;
      for (int i = 0; i < NUM_REGS; i++)
        if (addr[s] == ADDR_W'(i)) rmux[s] = regs[i];
      if (addr[s] == ADDR_STATUS)    rmux[s] = DATA_W'(status_in);
      else if (addr[s] == ADDR_PEND) rmux[s] = DATA_W'(pend[s]);
      else if (addr[s] == ADDR_ENA)  rmux[s] = DATA_W'(ena[s]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the shared regs are an array but are architecturally visible, so they are reset like any flop.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      for (int s = 0; s < 2; s++) begin
        pend[s]  <= '0;
        ena[s]   <= '0;
        ack[s]   <= 1'b0;
        rdata[s] <= '0;
        irq[s]   <= 1'b0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      for (int i = 0; i < NUM_REGS; i++)
        if (reg_we[i]) regs[i] <= reg_wd[i];
      for (int s = 0; s < 2; s++) begin
        pend[s]  <= (pend[s] & ~clr[s]) | set[s];
        if (ena_we[s]) ena[s] <= ena_wd[s];
        ack[s]   <= acc[s];
        rdata[s] <= (acc[s] && rw[s]) ? rmux[s] : '0;
        irq[s]   <= |(pend[s] & ena[s]);
      end
    end
  end

  assign a_acknowledge = ack[0];
  assign b_acknowledge = ack[1];
  assign a_read_data   = rdata[0];
  assign b_read_data   = rdata[1];
  assign a_irq         = irq[0];
  assign b_irq         = irq[1];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_out[i*DATA_W +: DATA_W] = regs[i];
  end

endmodule

// File: tb/tb_dual_master_regbank.sv
// Directed bench for dual_master_regbank (default parameters); byte-enable steps run when
// DUAL_MASTER_REGBANK_BYTEEN_EN is defined.
module tb_dual_master_regbank;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   status_in;
  logic [2:0]   a_address, b_address;
  logic         a_bus_enable, b_bus_enable;
  logic         a_rw, b_rw;
  logic [31:0]  a_write_data, b_write_data;
  logic [31:0]  a_read_data, b_read_data;
  logic         a_acknowledge, b_acknowledge;
  logic         a_irq, b_irq;
  logic [127:0] reg_out;
`ifdef DUAL_MASTER_REGBANK_BYTEEN_EN
  logic [3:0]   a_byteenable, b_byteenable;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic        a_ack1, b_ack1, a_ack2, b_ack2, a_irq1, b_irq1;
  logic [31:0] a_rd1, b_rd1, a_rd2, b_rd2;

  always #5 clk = ~clk;

  dual_master_regbank dut (
    .clk           (clk),
    .rst           (rst),
    .status_in     (status_in),
    .a_address     (a_address),
    .a_bus_enable  (a_bus_enable),
    .a_rw          (a_rw),
    .a_write_data  (a_write_data),
    .a_read_data   (a_read_data),
    .a_acknowledge (a_acknowledge),
    .a_irq         (a_irq),
    .b_address     (b_address),
    .b_bus_enable  (b_bus_enable),
    .b_rw          (b_rw),
    .b_write_data  (b_write_data),
    .b_read_data   (b_read_data),
    .b_acknowledge (b_acknowledge),
    .b_irq         (b_irq),
`ifdef DUAL_MASTER_REGBANK_BYTEEN_EN
    .a_byteenable  (a_byteenable),
    .b_byteenable  (b_byteenable),
`endif
    .reg_out       (reg_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access slot: drive at a falling edge, sample after the accepting edge and one edge later.
  task automatic xfer(input logic ae, input logic arw, input logic [2:0] aad, input logic [31:0] awd,
                      input logic be_, input logic brw, input logic [2:0] bad, input logic [31:0] bwd);
    @(negedge clk);
    a_bus_enable = ae;  a_rw = arw; a_address = aad; a_write_data = awd;
    b_bus_enable = be_; b_rw = brw; b_address = bad; b_write_data = bwd;
    @(negedge clk);
    a_ack1 = a_acknowledge; b_ack1 = b_acknowledge;
    a_rd1  = a_read_data;   b_rd1  = b_read_data;
    a_irq1 = a_irq;         b_irq1 = b_irq;
    a_bus_enable = 1'b0;    b_bus_enable = 1'b0;
    @(negedge clk);
    a_ack2 = a_acknowledge; b_ack2 = b_acknowledge;
    a_rd2  = a_read_data;   b_rd2  = b_read_data;
  endtask

  task automatic a_write(input logic [2:0] ad, input logic [31:0] d, input string tag);
    xfer(1'b1, 1'b0, ad, d, 1'b0, 1'b1, 3'd0, 32'h0);
    check({tag, "_ack"},     32'(a_ack1), 32'd1);
    check({tag, "_ack_off"}, 32'(a_ack2), 32'd0);
  endtask

  task automatic b_write(input logic [2:0] ad, input logic [31:0] d, input string tag);
    xfer(1'b0, 1'b1, 3'd0, 32'h0, 1'b1, 1'b0, ad, d);
    check({tag, "_ack"},     32'(b_ack1), 32'd1);
    check({tag, "_ack_off"}, 32'(b_ack2), 32'd0);
  endtask

  task automatic a_read(input logic [2:0] ad, input logic [31:0] exp, input string tag);
    xfer(1'b1, 1'b1, ad, 32'h0, 1'b0, 1'b1, 3'd0, 32'h0);
    check({tag, "_ack"},      32'(a_ack1), 32'd1);
    check(tag,                a_rd1,       exp);
    check({tag, "_ack_off"},  32'(a_ack2), 32'd0);
    check({tag, "_data_off"}, a_rd2,       32'h0);
  endtask

  task automatic b_read(input logic [2:0] ad, input logic [31:0] exp, input string tag);
    xfer(1'b0, 1'b1, 3'd0, 32'h0, 1'b1, 1'b1, ad, 32'h0);
    check({tag, "_ack"},      32'(b_ack1), 32'd1);
    check(tag,                b_rd1,       exp);
    check({tag, "_ack_off"},  32'(b_ack2), 32'd0);
    check({tag, "_data_off"}, b_rd2,       32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; status_in = 8'h00;
    a_address = '0; a_bus_enable = 1'b0; a_rw = 1'b1; a_write_data = '0;
    b_address = '0; b_bus_enable = 1'b0; b_rw = 1'b1; b_write_data = '0;
`ifdef DUAL_MASTER_REGBANK_BYTEEN_EN
    a_byteenable = 4'hF; b_byteenable = 4'hF;
`endif
    repeat (2) @(negedge clk);
    check("reset_a_ack", 32'(a_acknowledge), 32'd0);
    check("reset_b_ack", 32'(b_acknowledge), 32'd0);
    check("reset_a_rd",  a_read_data,        32'h0);
    check("reset_a_irq", 32'(a_irq),         32'd0);
    check("reset_b_irq", 32'(b_irq),         32'd0);
    for (int i = 0; i < 4; i++) check("reset_reg_out", reg_out[i*32 +: 32], 32'h0);
    rst = 1'b1;

    // Every address reads 0 out of reset, with a one-cycle ack.
    for (int k = 0; k < 8; k++) a_read(3'(k), 32'h0, "a_read_after_reset");
    check("reset_irqs", {30'b0, a_irq, b_irq}, 32'h0);

`ifdef DUAL_MASTER_REGBANK_BYTEEN_EN
    a_byteenable = 4'b0010;
    a_write(3'd2, 32'hFFFF_FFFF, "be_partial_wr");
    b_read(3'd2, 32'h0000_FF00, "be_partial_rd");
    b_read(3'd5, 32'h0000_0004, "be_partial_pend");
    b_write(3'd5, 32'h0000_000F, "be_w1c");
    a_byteenable = 4'b0000;
    a_write(3'd2, 32'h1234_5678, "be_zero_wr");
    b_read(3'd2, 32'h0000_FF00, "be_zero_reg");
    b_read(3'd5, 32'h0000_0000, "be_zero_pend");
    a_byteenable = 4'hF;
`endif

    // Doorbell: B enables, A writes its own reg 0.
    b_write(3'd6, 32'h0000_00FF, "b_enable_wr");
    a_write(3'd0, 32'hDEAD_BEEF, "a_reg0_wr");
    check("b_irq_at_write_edge", 32'(b_irq1), 32'd0);
    check("b_irq_one_later",     32'(b_irq),  32'd1);
    check("reg_out0",            reg_out[31:0], 32'hDEAD_BEEF);
    b_read(3'd0, 32'hDEAD_BEEF, "b_read_reg0");
    b_read(3'd5, 32'h0000_0001, "b_pending");
    b_read(3'd6, 32'h0000_000F, "b_enable_rd");
    a_read(3'd5, 32'h0000_0000, "a_pending_clear");

    // W1C drops irq one cycle later.
    b_write(3'd5, 32'h0000_0001, "b_w1c");
    check("b_irq_at_w1c_edge", 32'(b_irq1), 32'd1);
    check("b_irq_after_w1c",   32'(b_irq),  32'd0);
    b_read(3'd5, 32'h0, "b_pending_cleared");

    // Set and W1C on the same bit in the same cycle: set wins.
    xfer(1'b1, 1'b0, 3'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 3'd5, 32'h0000_0001);
    check("set_vs_w1c_a_ack", 32'(a_ack1), 32'd1);
    check("set_vs_w1c_b_ack", 32'(b_ack1), 32'd1);
    b_read(3'd5, 32'h0000_0001, "set_wins_pending");
    check("set_wins_irq", 32'(b_irq), 32'd1);
    b_write(3'd5, 32'h0000_0001, "b_w1c_again");

    // Non-owner write is ignored.
    a_write(3'd1, 32'h0000_1234, "a_nonowner_wr");
    check("nonowner_reg_out1", reg_out[63:32], 32'h0);
    b_read(3'd1, 32'h0, "nonowner_reg1");
    a_read(3'd5, 32'h0, "nonowner_a_pend");
    b_read(3'd5, 32'h0, "nonowner_b_pend");

    // B writes its reg 1: A pending set, but A irq stays low until enabled.
    b_write(3'd1, 32'h0000_0055, "b_reg1_wr");
    a_read(3'd5, 32'h0000_0002, "a_pending_bit1");
    check("a_irq_masked", 32'(a_irq), 32'd0);
    a_write(3'd6, 32'hFFFF_FFFF, "a_enable_all");
    check("a_irq_enabled", 32'(a_irq), 32'd1);
    a_read(3'd6, 32'h0000_000F, "a_enable_upper_zero");
    a_write(3'd6, 32'h0, "a_enable_off");
    check("a_irq_disabled", 32'(a_irq), 32'd0);
    a_read(3'd5, 32'h0000_0002, "a_pending_kept");

    // Status word is read-only and zero-extended.
    status_in = 8'hA5;
    b_read(3'd4, 32'h0000_00A5, "b_status");
    b_write(3'd4, 32'hFFFF_FFFF, "b_status_wr");
    b_read(3'd4, 32'h0000_00A5, "b_status_unchanged");

    // Simultaneous reads on both sides.
    xfer(1'b1, 1'b1, 3'd0, 32'h0, 1'b1, 1'b1, 3'd4, 32'h0);
    check("dual_a_ack", 32'(a_ack1), 32'd1);
    check("dual_b_ack", 32'(b_ack1), 32'd1);
    check("dual_a_rd",  a_rd1, 32'hDEAD_BEEF);
    check("dual_b_rd",  b_rd1, 32'h0000_00A5);

    // Unmapped address: write acked and dropped, read returns 0.
    a_write(3'd7, 32'hFFFF_FFFF, "a_unmapped_wr");
    a_read(3'd7, 32'h0, "a_unmapped_rd");

    // Read in the same cycle as the owner's write returns the old value.
    xfer(1'b1, 1'b0, 3'd0, 32'h1111_1111, 1'b1, 1'b1, 3'd0, 32'h0);
    check("read_old_value", b_rd1, 32'hDEAD_BEEF);
    a_read(3'd0, 32'h1111_1111, "read_new_value");

    // Held enable: one access every other cycle.
    @(negedge clk);
    a_bus_enable = 1'b1; a_rw = 1'b1; a_address = 3'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("held_enable_ack", 32'(a_acknowledge), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    a_bus_enable = 1'b0;

    // Reset in the middle of an ack cycle clears it at once.
    @(negedge clk);
    a_bus_enable = 1'b1; a_rw = 1'b1; a_address = 3'd0;
    @(posedge clk);
    #1;
    check("midreset_ack_before", 32'(a_acknowledge), 32'd1);
    rst = 1'b0;
    #1;
    check("midreset_ack",     32'(a_acknowledge), 32'd0);
    check("midreset_data",    a_read_data,        32'h0);
    check("midreset_reg_out", reg_out[31:0],      32'h0);
    a_bus_enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
